// File: rtl/store_drain_buffer_pkg.sv
// Shared store-path types: access sizes, drain FSM states and lane helpers.
package store_drain_buffer_pkg;

    typedef enum logic [2:0] {
        SB = 3'd0,
        SH = 3'd1,
        SW = 3'd2,
        SD = 3'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } drain_state_e;

    localparam int unsigned LANE_BYTES = 8;

    // Byte-enable mask for an access of the given size at byte offset off.
    function automatic logic [LANE_BYTES-1:0] byte_mask(input logic [2:0] size,
                                                        input logic [2:0] off);
        logic [LANE_BYTES-1:0] base;
        case (mem_size_e'(size))
            SB:      base = 8'h01;
            SH:      base = 8'h03;
            SW:      base = 8'h0F;
            SD:      base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    // True when the size is legal and the access stays inside one doubleword.
    function automatic logic store_fits(input logic [2:0] size,
                                        input logic [2:0] off);
        logic [3:0] nbytes;
        if (size > 3'd3) begin
            return 1'b0;
        end
        nbytes = 4'd1 << size[1:0];
        return ({1'b0, off} + nbytes) <= 4'd8;
    endfunction

endpackage

// File: rtl/sdb_fifo.sv
// Circular store-entry storage with per-entry valid and tag taps for conflict compare.
module sdb_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 61,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned STRB_W = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [TAG_W-1:0]                push_tag,
    input  logic [DATA_W-1:0]               push_data,
    input  logic [STRB_W-1:0]               push_strb,
    input  logic                            pop,
    output logic [TAG_W-1:0]                head_tag,
    output logic [DATA_W-1:0]               head_data,
    output logic [STRB_W-1:0]               head_strb,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            full,
    output logic                            empty,
    output logic [DEPTH-1:0][TAG_W-1:0]     tags,
    output logic [DEPTH-1:0]                valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [STRB_W-1:0] strb_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign head_tag  = tag_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign head_strb = strb_q[rd_ptr];

    // Entry write on push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                strb_q[i] <= '0;
            end
        end else if (push_ok) begin
            tag_q[wr_ptr]  <= push_tag;
            data_q[wr_ptr] <= push_data;
            strb_q[wr_ptr] <= push_strb;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry is live when its distance from the head is below the occupancy.
    always_comb begin
        valid = '0;
        tags  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] rel;
            rel      = PTR_W'(i) - rd_ptr;
            valid[i] = ({1'b0, rel} < count);
            tags[i]  = tag_q[i];
        end
    end

endmodule

// File: rtl/store_drain_buffer.sv
// Buffers committed stores and drains them oldest-first over a req/grant/ack bus.
module store_drain_buffer
    import store_drain_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic [DATA_WIDTH-1:0]     in_val,
    input  logic [2:0]                in_size,
    output logic                      in_ready,
    output logic                      misalign_err,
    input  logic [ADDR_WIDTH-1:0]     ld_check_addr,
    output logic                      ld_conflict,
    output logic                      bus_req,
    output logic [ADDR_WIDTH-1:0]     bus_addr,
    output logic [DATA_WIDTH-1:0]     bus_wdata,
    output logic [DATA_WIDTH/8-1:0]   bus_wstrb,
    input  logic                      bus_grant,
    input  logic                      bus_ack,
    output logic                      empty
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned TAG_W  = ADDR_WIDTH - 3;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    drain_state_e              state;
    logic [2:0]                in_off;
    logic                      in_legal;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic [STRB_W-1:0]         fmt_strb;
    logic [DATA_WIDTH-1:0]     fmt_wdata;
    logic [TAG_W-1:0]          head_tag;
    logic [DATA_WIDTH-1:0]     head_data;
    logic [STRB_W-1:0]         head_strb;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [DEPTH-1:0][TAG_W-1:0] fifo_tags;
    logic [DEPTH-1:0]          fifo_valid;
    logic [2:0]                unused_ld_offset;

    assign unused_ld_offset = ld_check_addr[2:0];

    // Lane formatting of the incoming store.
    assign in_off    = in_addr[2:0];
    assign in_legal  = store_fits(in_size, in_off);
    assign accept    = in_valid && in_ready;
    assign push      = accept && in_legal;
    assign fmt_strb  = STRB_W'(byte_mask(in_size, in_off));
    assign fmt_wdata = in_val << {in_off, 3'b000};

    assign pop = (state == WAIT_ACK) && bus_ack;

    sdb_fifo #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_WIDTH),
        .STRB_W (STRB_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_tag  (in_addr[ADDR_WIDTH-1:3]),
        .push_data (fmt_wdata),
        .push_strb (fmt_strb),
        .pop       (pop),
        .head_tag  (head_tag),
        .head_data (head_data),
        .head_strb (head_strb),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .tags      (fifo_tags),
        .valid     (fifo_valid)
    );

    assign in_ready  = !fifo_full;
    assign empty     = fifo_empty && (state == IDLE);
    assign bus_req   = (state == REQ);
    assign bus_addr  = bus_req ? {head_tag, 3'b000} : '0;
    assign bus_wdata = bus_req ? head_data : '0;
    assign bus_wstrb = bus_req ? head_strb : '0;

    // Drain sequencer: present head, wait for grant, then wait for the write ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (fifo_count != '0) state <= REQ;
                REQ:      if (bus_grant) state <= WAIT_ACK;
                WAIT_ACK: if (bus_ack) state <= (fifo_count > CNT_W'(1)) ? REQ : IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // One-cycle error pulse for a store that was consumed but dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= accept && !in_legal;
        end
    end

    // Doubleword match against live entries and the store being enqueued now.
    always_comb begin
        ld_conflict = push && (in_addr[ADDR_WIDTH-1:3] == ld_check_addr[ADDR_WIDTH-1:3]);
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_tags[i] == ld_check_addr[ADDR_WIDTH-1:3])) begin
                ld_conflict = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer with hand-computed expectations.
module tb_store_drain_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_addr;
    logic [63:0] in_val;
    logic [2:0]  in_size;
    logic        in_ready;
    logic        misalign_err;
    logic [63:0] ld_check_addr;
    logic        ld_conflict;
    logic        bus_req;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_grant;
    logic        bus_ack;
    logic        empty;

    int checks;
    int failures;

    store_drain_buffer #(
        .DEPTH      (4),
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_addr       (in_addr),
        .in_val        (in_val),
        .in_size       (in_size),
        .in_ready      (in_ready),
        .misalign_err  (misalign_err),
        .ld_check_addr (ld_check_addr),
        .ld_conflict   (ld_conflict),
        .bus_req       (bus_req),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_grant     (bus_grant),
        .bus_ack       (bus_ack),
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [63:0] a, input logic [63:0] v, input logic [2:0] s);
        in_valid = 1'b1;
        in_addr  = a;
        in_val   = v;
        in_size  = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic grant_then_ack();
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        bus_ack   = 1'b1;
        tick();
        bus_ack   = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_addr       = '0;
        in_val        = '0;
        in_size       = '0;
        ld_check_addr = '0;
        bus_grant     = 1'b0;
        bus_ack       = 1'b0;

        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_bus_addr", bus_addr, 64'd0);
        check("rst_bus_wdata", bus_wdata, 64'd0);
        check("rst_bus_wstrb", 64'(bus_wstrb), 64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);
        check("rst_ld_conflict", 64'(ld_conflict), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        reset = 1'b0;

        // SD at 0x1000, conflict visible while the store is being accepted.
        in_valid      = 1'b1;
        in_addr       = 64'h1000;
        in_val        = 64'h1122334455667788;
        in_size       = 3'd3;
        ld_check_addr = 64'h1000;
        #1;
        check("sd_accept_conflict", 64'(ld_conflict), 64'd1);
        tick();
        in_valid = 1'b0;
        check("sd_not_empty", 64'(empty), 64'd0);
        tick();
        check("sd_req", 64'(bus_req), 64'd1);
        check("sd_addr", bus_addr, 64'h1000);
        check("sd_strb", 64'(bus_wstrb), 64'hFF);
        check("sd_wdata", bus_wdata, 64'h1122334455667788);
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        check("sd_wait_ack_req", 64'(bus_req), 64'd0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("sd_empty_after_ack", 64'(empty), 64'd1);

        // SB lane shift.
        push_store(64'h2005, 64'hAB, 3'd0);
        tick();
        check("sb_req", 64'(bus_req), 64'd1);
        check("sb_addr", bus_addr, 64'h2000);
        check("sb_strb", 64'(bus_wstrb), 64'h20);
        check("sb_wdata", bus_wdata, 64'h0000AB0000000000);
        grant_then_ack();
        check("sb_empty", 64'(empty), 64'd1);

        // Fill to DEPTH with grant held low, then back-pressure and order.
        for (int i = 0; i < 4; i++) begin
            push_store(64'h5000 + 64'(8 * i), 64'hA0 + 64'(i), 3'd3);
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_head_addr", bus_addr, 64'h5000);
        in_valid = 1'b1;
        in_addr  = 64'h5020;
        in_val   = 64'hA4;
        in_size  = 3'd3;
        tick();
        check("full_held", 64'(in_ready), 64'd0);
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        bus_ack   = 1'b1;
        tick();
        bus_ack   = 1'b0;
        check("full_ready_after_pop", 64'(in_ready), 64'd1);
        check("full_no_idle_req", 64'(bus_req), 64'd1);
        tick();
        in_valid = 1'b0;
        check("full_fifth_accepted", 64'(in_ready), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("order_req_%0d", i), 64'(bus_req), 64'd1);
            check($sformatf("order_addr_%0d", i), bus_addr, 64'h5000 + 64'(8 * i));
            check($sformatf("order_data_%0d", i), bus_wdata, 64'hA0 + 64'(i));
            grant_then_ack();
        end
        check("order_empty", 64'(empty), 64'd1);

        // Doubleword-crossing SW and illegal size are consumed and dropped.
        push_store(64'h3006, 64'h12345678, 3'd2);
        check("sw_cross_err", 64'(misalign_err), 64'd1);
        check("sw_cross_empty", 64'(empty), 64'd1);
        tick();
        check("sw_cross_err_pulse", 64'(misalign_err), 64'd0);
        check("sw_cross_no_req", 64'(bus_req), 64'd0);
        push_store(64'h3000, 64'h1, 3'd5);
        check("size5_err", 64'(misalign_err), 64'd1);
        tick();
        check("size5_no_req", 64'(bus_req), 64'd0);
        check("size5_empty", 64'(empty), 64'd1);

        // Load conflict against a buffered SH.
        push_store(64'h4002, 64'hBEEF, 3'd1);
        ld_check_addr = 64'h4007;
        #1;
        check("ld_same_dw", 64'(ld_conflict), 64'd1);
        ld_check_addr = 64'h4008;
        #1;
        check("ld_next_dw", 64'(ld_conflict), 64'd0);
        ld_check_addr = 64'h4007;
        tick();
        check("sh_strb", 64'(bus_wstrb), 64'h0C);
        check("sh_wdata", bus_wdata, 64'h00000000BEEF0000);
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        check("ld_conflict_wait_ack", 64'(ld_conflict), 64'd1);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("ld_after_drain", 64'(ld_conflict), 64'd0);

        // Reset during WAIT_ACK with three entries; stale ack afterwards.
        push_store(64'h6000, 64'h60, 3'd3);
        push_store(64'h6008, 64'h61, 3'd3);
        push_store(64'h6010, 64'h62, 3'd3);
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        check("rst_mid_pre_empty", 64'(empty), 64'd0);
        ld_check_addr = 64'h6008;
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_empty", 64'(empty), 64'd1);
        check("rst_mid_req", 64'(bus_req), 64'd0);
        check("rst_mid_ready", 64'(in_ready), 64'd1);
        check("rst_mid_conflict", 64'(ld_conflict), 64'd0);
        #1;
        reset   = 1'b0;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("stale_ack_empty", 64'(empty), 64'd1);
        tick();
        check("stale_ack_req", 64'(bus_req), 64'd0);

        // Asynchronous drop of bus_req while in REQ.
        push_store(64'h7000, 64'h70, 3'd3);
        tick();
        check("async_pre_req", 64'(bus_req), 64'd1);
        reset = 1'b1;
        #1;
        check("async_req_drop", 64'(bus_req), 64'd0);
        check("async_addr_clear", bus_addr, 64'd0);
        #1;
        reset = 1'b0;
        tick();
        check("async_post_empty", 64'(empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_drain_buffer.md
# store_drain_buffer

Bounded store queue that receives committed stores from the writeback stage's pending-write interface (address, value, size, write-enable) and drains them, oldest first, to the data-memory bus with a request/grant/acknowledge handshake. It sits between writeback and the memory port, turning the single-cycle store issue into a buffered bus transaction. It back-pressures the pipeline when full and flags younger loads that hit a not-yet-drained store.

## Interface
- DEPTH, 4, number of store entries (power of two, ≥2)
- ADDR_WIDTH, 64, byte address width
- DATA_WIDTH, 64, store data / bus data width (bus is one doubleword)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  store from writeback is committed this cycle
- in_addr  in  ADDR_WIDTH  store byte address
- in_val  in  DATA_WIDTH  store value, right-justified
- in_size  in  3  RISC-V funct3: 0=SB, 1=SH, 2=SW, 3=SD; other values illegal
- in_ready  out  1  buffer can accept a store this cycle
- misalign_err  out  1  one-cycle pulse: accepted store was illegal or crossed a doubleword
- ld_check_addr  in  ADDR_WIDTH  address of load in memory stage
- ld_conflict  out  1  load doubleword matches a buffered store
- bus_req  out  1  store request to memory
- bus_addr  out  ADDR_WIDTH  doubleword-aligned address (bits [2:0] = 0)
- bus_wdata  out  DATA_WIDTH  lane-shifted data
- bus_wstrb  out  DATA_WIDTH/8  byte-enable mask
- bus_grant  in  1  memory accepted the request
- bus_ack  in  1  memory write completed
- empty  out  1  no buffered stores and FSM idle

## Operation
- Accept: in_valid && in_ready. in_ready = (count < DEPTH); no same-cycle bypass of a pop.
- Lane formatting at enqueue: off = in_addr[2:0]; nbytes = 1<<in_size; strb = ((1<<nbytes)-1) << off; wdata = in_val << (8*off); stored addr = {in_addr[63:3], 3'b000}.
- Illegal in_size (≥4) or off+nbytes > 8: store consumes the handshake, is NOT enqueued, misalign_err pulses next cycle.
- Drain FSM: IDLE → REQ when count>0. REQ: bus_req=1, bus_addr/wdata/wstrb from head, held stable until bus_grant=1 → WAIT_ACK. WAIT_ACK: bus_req=0, wait bus_ack; on bus_ack pop head, then → REQ if count-1>0 else IDLE.
- bus_grant ignored outside REQ; bus_ack ignored outside WAIT_ACK.
- ld_conflict (combinational) = any valid entry (including head in REQ/WAIT_ACK, and a store being accepted this cycle) whose addr[63:3] == ld_check_addr[63:3].
- empty = (count==0) && state==IDLE.
- Simultaneous enqueue and pop: both occur; count unchanged; pointers wrap modulo DEPTH.

## Timing
- Reset values: in_ready=1, bus_req=0, bus_addr/wdata/wstrb=0, misalign_err=0, ld_conflict=0 (no entries), empty=1, state=IDLE, count=0, pointers=0.
- Accept at edge N → bus_req high from cycle N+1 (buffer was empty).
- Minimum per store: 1 cycle REQ (grant same cycle) + 1 cycle WAIT_ACK (ack same cycle) = 2 cycles; back-to-back entries give no idle cycle between ack and next REQ.
- in_ready rises the cycle after the popping edge when full.
- Reset asserted mid-transaction: bus_req drops asynchronously, all entries discarded; a pending bus_ack after reset is ignored.

## Structure
- Shared pipeline package: mem_size_e enum (SB/SH/SW/SD), drain state enum (IDLE/REQ/WAIT_ACK), function byte_mask(size, off).
- One sub-module: sdb_fifo (DEPTH-entry circular storage of {addr, wdata, wstrb}, push/pop, count, full/empty, parallel address outputs for conflict compare). FSM, formatting and conflict logic in store_drain_buffer.

## Test plan
- Reset, then SD addr 0x1000 val 0x1122334455667788 → next cycle bus_req=1, bus_addr=0x1000, wstrb=0xFF; grant then ack → empty=1 next cycle.
- SB addr 0x2005 val 0xAB → bus_addr=0x2000, wstrb=0x20, wdata=0x0000AB0000000000.
- Fill 4 stores with bus_grant=0 → in_ready=0 after 4th; 5th held; grant+ack one → in_ready=1 next cycle, 5th accepted, order preserved on bus.
- SW at addr 0x3006 → misalign_err pulse, no bus_req, count stays 0; in_size=5 likewise.
- Buffered SH at 0x4002, ld_check_addr=0x4007 → ld_conflict=1; 0x4008 → 0; after ack → 0 for 0x4007.
- Reset asserted during WAIT_ACK with 3 entries → bus_req=0, empty=1 immediately; later bus_ack causes no pop or state change.
